// File: rtl/shared_port_arbiter_pkg.sv
// Shared types and limits for the shared-port arbiter.
//   arb_state_e     : arbiter FSM states (IDLE / GRANT / GAP)
//   MAX_REQUESTERS  : upper bound on the number of requesters
package shared_port_arbiter_pkg;

  localparam int MAX_REQUESTERS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/shared_port_arbiter_rr_picker.sv
// Combinational round-robin selector: finds the first set request bit at or
// above ptr, wrapping modulo N.
//   req : request vector
//   ptr : search start index
//   gnt : one-hot of the selected requester (zero when nothing requested)
//   idx : index of the selected requester
//   any : at least one request bit set
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down to offset 0 so the nearest hit to
  // ptr is the last one written and therefore wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_port_arbiter.sv
// Round-robin arbiter for one resource port shared by N requesters.
// A grant is held until the owner pulses i_done or drops i_req, followed by
// a one-cycle GAP with no grant before the next selection.
// Optional feature macro: SHARED_PORT_ARBITER_TIMEOUT_EN -- revokes a grant
// after MAX_HOLD cycles and pulses o_timeout; when undefined grants are
// unbounded and o_timeout is tied low.
//   i_clk     : clock
//   i_rst_n   : async active-low reset
//   i_req     : per-requester request level
//   i_done    : per-requester release pulse (owner's bit only)
//   o_gnt     : registered one-hot grant
//   o_owner   : current owner index (valid while o_busy)
//   o_busy    : resource granted
//   o_timeout : one-cycle pulse after a MAX_HOLD revocation
module shared_port_arbiter
  import shared_port_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N-1:0]         i_req,
  input  logic [N-1:0]         i_done,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_owner,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > MAX_REQUESTERS || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("shared_port_arbiter: N or MAX_HOLD out of range");
  end

  arb_state_e    state;
  logic [IW-1:0] rr_ptr;
  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          owner_release;
  logic          hold_limit;
  logic [IW-1:0] next_ptr;

  rr_picker #(.N(N), .IW(IW)) u_pick (
    .req (i_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Only the owner's done/req bits matter; everything else is ignored.
  assign owner_release = i_done[o_owner] | ~i_req[o_owner];
  assign next_ptr      = (o_owner == IW'(N - 1)) ? '0 : o_owner + IW'(1);

`ifdef SHARED_PORT_ARBITER_TIMEOUT_EN
  logic [7:0] hold_cnt;
  assign hold_limit = (hold_cnt == 8'(MAX_HOLD - 1));
`else
  assign hold_limit = 1'b0;
  assign o_timeout  = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_gnt   <= '0;
      o_owner <= '0;
      o_busy  <= 1'b0;
      rr_ptr  <= '0;
`ifdef SHARED_PORT_ARBITER_TIMEOUT_EN
      hold_cnt  <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
`ifdef SHARED_PORT_ARBITER_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_any) begin
            state   <= GRANT;
            o_gnt   <= pick_gnt;
            o_owner <= pick_idx;
            o_busy  <= 1'b1;
`ifdef SHARED_PORT_ARBITER_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (owner_release || hold_limit) begin
            state  <= GAP;
            o_gnt  <= '0;
            o_busy <= 1'b0;
            rr_ptr <= next_ptr;
`ifdef SHARED_PORT_ARBITER_TIMEOUT_EN
            hold_cnt  <= '0;
            // A release coinciding with the limit counts as a normal release.
            o_timeout <= ~owner_release;
`endif
          end else begin
`ifdef SHARED_PORT_ARBITER_TIMEOUT_EN
            hold_cnt <= hold_cnt + 8'd1;
`endif
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
